// File: rtl/block_dist_pkg.sv
// Shared defaults, FSM state type and lane-slicing helper for the PCS TX
// round-robin block distributor.
package block_dist_pkg;

  localparam int unsigned DEF_LEN_CODED_BLOCK = 32'd66;
  localparam int unsigned DEF_N_LANES         = 32'd20;
  localparam int unsigned DEF_AM_PERIOD       = 32'd16384;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    GAP  = 1'b1
  } dist_state_e;

  // Width of the flat output bus carrying one block per lane.
  function automatic int unsigned lane_bus_width(input int unsigned n_lanes,
                                                 input int unsigned len_block);
    return n_lanes * len_block;
  endfunction

endpackage

// File: rtl/block_dist_am_timer.sv
// Alignment-marker gap timer: counts completed rounds and, every AM_PERIOD
// rounds, closes the input for N_LANES cycles. Built only with BLOCK_DIST_AM_GAP_EN.
module block_dist_am_timer
  import block_dist_pkg::*;
#(
  parameter int unsigned N_LANES   = DEF_N_LANES,
  parameter int unsigned AM_PERIOD = DEF_AM_PERIOD
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic round_done,
  output logic o_ready,
  output logic o_am_slot,
  output logic gap_done
);

  localparam int unsigned PTR_W = $clog2(N_LANES);
  localparam int unsigned RND_W = $clog2(AM_PERIOD);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(AM_PERIOD - 32'd1);
  localparam logic [PTR_W-1:0] GAP_LAST = PTR_W'(N_LANES - 32'd1);

  dist_state_e      state_r, state_nxt_s;
  logic [RND_W-1:0] rnd_cnt_r, rnd_cnt_nxt_s;
  logic [PTR_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic             ready_r, ready_nxt_s;
  logic             am_slot_r, am_slot_nxt_s;

  // Next-state logic: clear aborts a gap and restarts the round count.
  always_comb begin
    state_nxt_s   = state_r;
    rnd_cnt_nxt_s = rnd_cnt_r;
    gap_cnt_nxt_s = gap_cnt_r;
    ready_nxt_s   = ready_r;
    am_slot_nxt_s = 1'b0;
    if (i_clear) begin
      state_nxt_s   = FILL;
      rnd_cnt_nxt_s = '0;
      gap_cnt_nxt_s = '0;
      ready_nxt_s   = 1'b1;
    end else begin
      case (state_r)
        FILL: begin
          ready_nxt_s = 1'b1;
          if (round_done) begin
            if (rnd_cnt_r == RND_LAST) begin
              state_nxt_s   = GAP;
              rnd_cnt_nxt_s = '0;
              gap_cnt_nxt_s = '0;
              ready_nxt_s   = 1'b0;
              am_slot_nxt_s = 1'b1;
            end else begin
              rnd_cnt_nxt_s = rnd_cnt_r + RND_W'(1);
            end
          end else begin
            rnd_cnt_nxt_s = rnd_cnt_r;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_nxt_s   = FILL;
            gap_cnt_nxt_s = '0;
            ready_nxt_s   = 1'b1;
          end else begin
            gap_cnt_nxt_s = gap_cnt_r + PTR_W'(1);
            ready_nxt_s   = 1'b0;
          end
        end
        default: begin
          state_nxt_s   = FILL;
          rnd_cnt_nxt_s = '0;
          gap_cnt_nxt_s = '0;
          ready_nxt_s   = 1'b1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= FILL;
      rnd_cnt_r <= '0;
      gap_cnt_r <= '0;
      ready_r   <= 1'b1;
      am_slot_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rnd_cnt_r <= rnd_cnt_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
      ready_r   <= ready_nxt_s;
      am_slot_r <= am_slot_nxt_s;
    end
  end

  assign o_ready   = ready_r;
  assign o_am_slot = am_slot_r;
  assign gap_done  = (state_r == GAP) && (gap_cnt_r == GAP_LAST);

endmodule

// File: rtl/block_distribution_rr.sv
// Round-robin distributor of 64b/66b coded blocks onto N_LANES PCS lanes.
// Define BLOCK_DIST_AM_GAP_EN to build the periodic alignment-marker input gap.
module block_distribution_rr
  import block_dist_pkg::*;
#(
  parameter int unsigned LEN_CODED_BLOCK = DEF_LEN_CODED_BLOCK,
  parameter int unsigned N_LANES         = DEF_N_LANES,
  parameter int unsigned AM_PERIOD       = DEF_AM_PERIOD,
  parameter int unsigned PTR_W           = $clog2(N_LANES),
  parameter int unsigned RND_W           = $clog2(AM_PERIOD)
) (
  input  logic                                                 i_clock,
  input  logic                                                 i_reset_n,
  input  logic [LEN_CODED_BLOCK-1:0]                           i_data,
  input  logic                                                 i_valid,
  output logic                                                 o_ready,
  input  logic                                                 i_clear,
  output logic [lane_bus_width(N_LANES, LEN_CODED_BLOCK)-1:0] o_data,
  output logic                                                 o_valid,
  output logic [PTR_W-1:0]                                     o_lane_ptr,
  output logic                                                 o_am_slot
);

  localparam int unsigned      BUS_W    = lane_bus_width(N_LANES, LEN_CODED_BLOCK);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_LANES - 32'd1);

  if (N_LANES < 32'd2 || AM_PERIOD < 32'd2 || PTR_W < 32'd1 || RND_W < 32'd1) begin : g_bad_params
    $error("block_distribution_rr: N_LANES and AM_PERIOD must both be at least 2");
  end

  logic [PTR_W-1:0]           ptr_r, ptr_nxt_s;
  logic [LEN_CODED_BLOCK-1:0] staging_r [N_LANES-1];
  logic [BUS_W-1:0]           data_r, round_s;
  logic                       valid_r;
  logic                       ready_s, xfer_s, last_s, round_done_s, gap_done_s;

  assign xfer_s       = i_valid && ready_s && !i_clear;
  assign last_s       = (ptr_r == PTR_LAST);
  assign round_done_s = xfer_s && last_s;

`ifdef BLOCK_DIST_AM_GAP_EN
  block_dist_am_timer #(
    .N_LANES   (N_LANES),
    .AM_PERIOD (AM_PERIOD)
  ) u_am_timer (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_clear    (i_clear),
    .round_done (round_done_s),
    .o_ready    (ready_s),
    .o_am_slot  (o_am_slot),
    .gap_done   (gap_done_s)
  );
`else
  assign ready_s    = 1'b1;
  assign o_am_slot  = 1'b0;
  assign gap_done_s = 1'b0;
`endif

  // Lane pointer: restarts on clear or at the end of an AM gap.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (i_clear || gap_done_s) begin
      ptr_nxt_s = '0;
    end else if (xfer_s) begin
      ptr_nxt_s = last_s ? '0 : ptr_r + PTR_W'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Completed round: staged lanes plus the incoming block as the last lane.
  always_comb begin
    round_s = '0;
    for (int k = 0; k < N_LANES - 1; k++) begin
      round_s[k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK] = staging_r[k];
    end
    round_s[(N_LANES-1)*LEN_CODED_BLOCK +: LEN_CODED_BLOCK] = i_data;
  end

  // Staging lanes 0..N_LANES-2; the last lane never needs to be stored.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < N_LANES - 1; k++) begin
        staging_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_LANES - 1; k++) begin
        if (xfer_s && (ptr_r == PTR_W'(k))) begin
          staging_r[k] <= i_data;
        end else begin
          staging_r[k] <= staging_r[k];
        end
      end
    end
  end

  // Pointer and output register; o_data holds until the next completed round.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_r   <= '0;
      valid_r <= 1'b0;
      data_r  <= '0;
    end else begin
      ptr_r   <= ptr_nxt_s;
      valid_r <= round_done_s;
      if (round_done_s) begin
        data_r <= round_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign o_ready    = ready_s;
  assign o_data     = data_r;
  assign o_valid    = valid_r;
  assign o_lane_ptr = ptr_r;

endmodule

// File: tb/tb_block_distribution_rr.sv
// Scoreboard bench for block_distribution_rr (4 lanes, AM period 3); adapts its
// gap expectations to whether BLOCK_DIST_AM_GAP_EN is defined.
module tb_block_distribution_rr;

  localparam int unsigned L   = 66;
  localparam int unsigned N   = 4;
  localparam int unsigned AMP = 3;
  localparam int unsigned PW  = $clog2(N);
  localparam int unsigned BW  = N * L;
`ifdef BLOCK_DIST_AM_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic          i_clock = 1'b0;
  logic          i_reset_n;
  logic [L-1:0]  i_data;
  logic          i_valid;
  logic          i_clear;
  logic          o_ready;
  logic [BW-1:0] o_data;
  logic          o_valid;
  logic [PW-1:0] o_lane_ptr;
  logic          o_am_slot;

  block_distribution_rr #(
    .LEN_CODED_BLOCK (L),
    .N_LANES         (N),
    .AM_PERIOD       (AMP)
  ) dut (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_clear    (i_clear),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_lane_ptr (o_lane_ptr),
    .o_am_slot  (o_am_slot)
  );

  always #5 i_clock = ~i_clock;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [BW-1:0] sb_q[$];
  logic [BW-1:0] last_round;

  // reference model state
  int            m_ptr, m_rnd, m_gap;
  logic [L-1:0]  m_stage [N];
  logic          m_valid, m_acc;

  task automatic check_val(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_rnd = 0;
    m_gap = 0;
    m_valid = 1'b0;
    m_acc = 1'b0;
    last_round = '0;
    sb_q.delete();
    for (int k = 0; k < N; k++) m_stage[k] = '0;
  endtask

  // One clock: check current outputs, drive, update the model, check o_valid/o_data.
  task automatic cycle(input logic v, input logic [L-1:0] d, input logic c);
    logic [BW-1:0] rnd_v;
    check_val("o_ready", o_ready, (m_gap == 0));
    check_val("o_am_slot", o_am_slot, (m_gap == N));
    check_val("o_lane_ptr", o_lane_ptr, m_ptr);
    i_valid = v;
    i_data  = d;
    i_clear = c;
    m_acc   = 1'b0;
    m_valid = 1'b0;
    @(posedge i_clock);
    if (c) begin
      m_ptr = 0;
      m_rnd = 0;
      m_gap = 0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (v) begin
      m_acc = 1'b1;
      if (m_ptr == N - 1) begin
        for (int k = 0; k < N - 1; k++) rnd_v[k*L +: L] = m_stage[k];
        rnd_v[(N-1)*L +: L] = d;
        sb_q.push_back(rnd_v);
        m_valid = 1'b1;
        m_ptr = 0;
        m_rnd++;
        if (GAP_EN && m_rnd == AMP) begin
          m_rnd = 0;
          m_gap = N;
        end
      end else begin
        m_stage[m_ptr] = d;
        m_ptr++;
      end
    end
    @(negedge i_clock);
    check_val("o_valid", o_valid, m_valid);
    if (o_valid && sb_q.size() > 0) begin
      last_round = sb_q.pop_front();
      check_val("o_data", o_data, last_round);
    end
  endtask

  // Hold a block on the input until it is accepted.
  task automatic send(input logic [L-1:0] d);
    int tries = 0;
    do begin
      cycle(1'b1, d, 1'b0);
      tries++;
    end while (!m_acc && tries < 2 * N + 2);
    if (!m_acc) begin
      n_fail++;
      $display("FAIL send_timeout: block %0h not accepted after %0d cycles", d, tries);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data"}, o_data, '0);
    check_val({tag, "_valid"}, o_valid, 1'b0);
    check_val({tag, "_ready"}, o_ready, 1'b1);
    check_val({tag, "_ptr"}, o_lane_ptr, '0);
    check_val({tag, "_am"}, o_am_slot, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BW-1:0] exp_round;
    logic [L-1:0]  rd;
    int            low;

    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_clear   = 1'b0;
    i_data    = '0;
    model_reset();
    repeat (3) @(negedge i_clock);
    check_reset_outputs("reset");
    i_reset_n = 1'b1;

    // continuous fill
    for (int i = 1; i <= 4; i++) send(L'(i));
    exp_round = {66'h4, 66'h3, 66'h2, 66'h1};
    check_val("fill_round", o_data, exp_round);
    check_val("fill_ptr", o_lane_ptr, '0);
    idle(1);

    // AM gap: restart the round count, then three rounds back-to-back
    cycle(1'b0, '0, 1'b1);
    for (int i = 1; i <= 12; i++) send(L'(32'h10 + i));
    low = 0;
    for (int i = 0; i < N + 1; i++) begin
      if (!o_ready) low++;
      cycle(1'b0, '0, 1'b0);
    end
    check_val("gap_len", low, GAP_EN ? N : 0);
    check_val("gap_ptr", o_lane_ptr, '0);
    for (int i = 1; i <= 4; i++) send(L'(32'h20 + i));
    exp_round = {66'h24, 66'h23, 66'h22, 66'h21};
    check_val("post_gap_round", o_data, exp_round);

    // bubbles between blocks
    for (int i = 1; i <= 4; i++) begin
      send(L'(32'h30 + i));
      idle(3);
    end
    exp_round = {66'h34, 66'h33, 66'h32, 66'h31};
    check_val("bubble_round", o_data, exp_round);

    // clear mid-round drops the simultaneous block and keeps o_data
    send(L'(32'hA));
    send(L'(32'hB));
    cycle(1'b1, L'(32'hC), 1'b1);
    check_val("clr_hold_data", o_data, exp_round);
    for (int i = 32'hD; i <= 32'h10; i++) send(L'(i));
    exp_round = {66'h10, 66'hF, 66'hE, 66'hD};
    check_val("clr_round", o_data, exp_round);

    // run until a gap opens (or 16 blocks), then clear on its first cycle
    for (int i = 0; i < 16 && m_gap == 0; i++) send(L'(32'h40 + i));
    cycle(1'b1, L'(32'h4F), 1'b1);
    for (int i = 1; i <= 4; i++) send(L'(32'h50 + i));
    exp_round = {66'h54, 66'h53, 66'h52, 66'h51};
    check_val("clr_gap_round", o_data, exp_round);

    // asynchronous reset between clock edges, mid-round
    send(L'(32'h61));
    send(L'(32'h62));
    #2 i_reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge i_clock);
    i_reset_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 4; i++) send(L'(32'h70 + i));
    exp_round = {66'h74, 66'h73, 66'h72, 66'h71};
    check_val("rst_round", o_data, exp_round);

    // random traffic with occasional clears
    for (int i = 0; i < 80; i++) begin
      rd = {$urandom, $urandom, $urandom};
      cycle($urandom_range(0, 3) != 0, rd, $urandom_range(0, 19) == 0);
    end

    idle(2);
    check_val("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_distribution_rr.md
Name: block_distribution_rr

Overview:
- Parametrised round-robin distributor for the 100GbE PCS TX path, placed between the 64b/66b encoder/scrambler and the alignment-marker inserter.
- Accepts one coded block per cycle with a valid/ready handshake and assigns it to the next PCS lane using an internal lane pointer. No external address is used.
- When a full round is collected, presents all lanes in parallel as one flat bus with a one-cycle strobe.
- Periodically opens an N_LANES-cycle input gap so the downstream AM inserter can place alignment markers.

Parameters:
- LEN_CODED_BLOCK, 66, width of one coded block.
- N_LANES, 20, number of PCS lanes (>=2).
- AM_PERIOD, 16384, completed rounds between AM gaps (>=2).
- PTR_W, $clog2(N_LANES), lane pointer width (derived; do not override).
- RND_W, $clog2(AM_PERIOD), round counter width (derived).

Ports:
- i_clock  in  1  single clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_data  in  LEN_CODED_BLOCK  coded block.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  block accepts a transfer this cycle.
- i_clear  in  1  synchronous realign: drop the partial round and restart at lane 0.
- o_data  out  N_LANES*LEN_CODED_BLOCK  lane k at bits [k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK].
- o_valid  out  1  one-cycle strobe: o_data holds a complete round.
- o_lane_ptr  out  PTR_W  lane that the next accepted block will be written to.
- o_am_slot  out  1  one-cycle pulse on the first gap cycle.

Behaviour:
- Reset values: o_data=0, o_valid=0, o_ready=1, o_lane_ptr=0, o_am_slot=0, round counter=0, state=FILL. Reset is effective mid-round; the partial round is discarded.
- Transfer occurs when i_valid && o_ready.
- FILL state: o_ready=1.
  - A transfer writes i_data into staging[ptr].
  - ptr increments and wraps from N_LANES-1 to 0.
- On a transfer with ptr==N_LANES-1:
  - o_data is loaded with staging[0..N_LANES-2] plus i_data as lane N_LANES-1.
  - o_valid=1 on the next cycle only. Latency is last block accepted at t -> o_valid at t+1.
  - The round counter increments.
- Staging is single-buffered, but the output register is separate. The next round can start on the cycle after the last block with no stall. o_data holds its value until the next completed round.
- Round counter reaching AM_PERIOD on a completion: the counter is cleared to 0 and the state moves to GAP.
- GAP state:
  - o_ready=0 for exactly N_LANES cycles, timed by the gap counter.
  - o_am_slot=1 on the first GAP cycle only.
  - The state returns to FILL with ptr=0.
  - i_valid during GAP is ignored; the source must hold data per the handshake.
- i_clear takes precedence over everything except reset:
  - ptr=0, round counter=0, state=FILL, o_valid=0.
  - A simultaneous transfer is dropped.
  - o_data is not cleared.
  - i_clear during GAP aborts the gap.
- Idle cycles (i_valid=0) in FILL: ptr and staging hold; rounds may be assembled across gaps of any length.
- No overflow is possible; the counters wrap only as specified above.

Optional Feature:
- Macro: BLOCK_DIST_AM_GAP_EN.
- Defined: AM gap logic, GAP state and o_am_slot behave as above.
- Undefined:
  - No gap counter or round counter is built, and o_ready is tied to 1.
  - o_am_slot is tied to 0.
  - Rounds are emitted continuously.

Decomposition:
- Package block_dist_pkg:
  - default LEN_CODED_BLOCK and N_LANES constants;
  - default AM_PERIOD;
  - state enum {FILL, GAP};
  - lane-slice width helper.
- Sub-module block_dist_am_timer contains:
  - round counter and gap counter;
  - FILL/GAP FSM;
  - outputs o_ready, o_am_slot, gap_done.
- It is instantiated only under BLOCK_DIST_AM_GAP_EN.
- The top module keeps the pointer, staging and output register.

Test Plan:
- Continuous fill (N_LANES=4, AM_PERIOD=3): send blocks 0x1..0x4 back-to-back -> o_valid one cycle after 0x4; o_data lanes 0..3 = 0x1,0x2,0x3,0x4; o_lane_ptr=0.
- AM gap (N_LANES=4, AM_PERIOD=3): send 12 blocks continuously.
  - Expect o_valid after blocks 4, 8 and 12.
  - After the third round, o_ready=0 for exactly 4 cycles, with o_am_slot=1 on the first of them.
  - o_ready returns to 1 and the next block lands in lane 0.
- Bubbles: 4 blocks with i_valid low for 3 cycles between each -> a single o_valid with correct lane ordering; ptr is stable during bubbles.
- Clear mid-round: send 0xA,0xB, then assert i_clear together with 0xC, then send 0xD..0x10 -> 0xC is dropped; the next round has lanes = 0xD,0xE,0xF,0x10; the round counter restarts.
- Async reset mid-round: drop i_reset_n between clock edges after 2 blocks -> all outputs go to their reset values immediately; the next 4 blocks form a fresh round starting at lane 0.
- Macro off, default params (N_LANES=20): 16384×20+20 blocks back-to-back -> o_ready is never low, o_am_slot is never high, and o_valid fires every 20 cycles.
